// File: rtl/gpu_bg_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : gpu_bg_pkg
//  Purpose : Shared types and constants for the BG cache-line block mover.
//            The FSM state encoding, block geometry and the per-beat
//            byte-enable helper live here.
//  Rev     : 1.0  initial release
// ============================================================================
package gpu_bg_pkg;

  localparam int BG_BLOCK_BITS = 256;  // 16 pixels x 16 bits
  localparam int BG_BEATS      = 8;    // 32-bit words per block
  localparam int BG_ADR_W      = 15;   // block address {Y[8:0], X[9:4]}

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SAVE      = 3'd1,
    ST_LOAD_CMD  = 3'd2,
    ST_LOAD_WAIT = 3'd3,
    ST_DONE      = 3'd4
  } bgState_e;

  // Each 32-bit beat holds two pixels; each pixel mask bit covers two bytes.
  function automatic logic [3:0] beat_byte_en(input logic [15:0] mask,
                                              input logic [2:0]  k);
    logic lo;
    logic hi;
    lo = mask[{k, 1'b0}];
    hi = mask[{k, 1'b1}];
    return {hi, hi, lo, lo};
  endfunction

endpackage
`default_nettype wire

// File: rtl/gpu_bg_read_assembler.sv
`default_nettype none
// ============================================================================
//  Module  : gpu_bg_read_assembler
//  Purpose : Collects in-order 32-bit read beats into a 256-bit block.
//  Ports   : clk, i_rst      clock / synchronous active-high reset
//            i_clear         restart assembly (start of a load)
//            i_capture       a read beat is present on i_rdData
//            i_rdData        read data word
//            o_block         assembled block, word n at bits [32n+31:32n]
//            o_lastBeat      the current capture is the 8th beat
//  Rev     : 1.0  initial release
// ============================================================================
module gpu_bg_read_assembler
  import gpu_bg_pkg::*;
(
  input  logic                     clk,
  input  logic                     i_rst,
  input  logic                     i_clear,
  input  logic                     i_capture,
  input  logic [31:0]              i_rdData,
  output logic [BG_BLOCK_BITS-1:0] o_block,
  output logic                     o_lastBeat
);

  logic [3:0]               r_count;
  logic                     r_full;
  logic [BG_BLOCK_BITS-1:0] r_block;
  logic                     w_take;

  // Once full, surplus beats are dropped so a 9th beat can never overwrite word 0.
  assign w_take     = i_capture & ~r_full;
  assign o_lastBeat = w_take & (r_count == 4'd7);
  assign o_block    = r_block;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_count <= '0;
      r_full  <= 1'b0;
      r_block <= '0;
    end else if (i_clear) begin
      r_count <= '0;
      r_full  <= 1'b0;
      r_block <= '0;
    end else if (w_take) begin
      r_block[{r_count[2:0], 5'd0} +: 32] <= i_rdData;
      r_count <= r_count + 4'd1;
      if (r_count == 4'd7) r_full <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/gpu_bg_block_mover.sv
`default_nettype none
// ============================================================================
//  Module  : gpu_bg_block_mover
//  Purpose : Writes the dirty halfwords of an exported BG block back to VRAM
//            and fetches the next block, returning it with a 1-clock pulse.
//  Ports   : clk, i_rst                      clock / sync active-high reset
//            i_req, i_doSave, i_doLoad       request strobe and its operations
//            i_saveAdr, i_loadAdr            block addresses
//            i_exportedBGBlock/MSKBGBlock    block data and pixel write mask
//            o_busy, o_done                  request status
//            o_importBGBlockSingleClock,
//            o_importedBGBlock               fetched block and its valid pulse
//            o_mem*/i_mem*                   32-bit word bus to the arbiter
//  Rev     : 1.0  initial release
// ============================================================================
module gpu_bg_block_mover
  import gpu_bg_pkg::*;
#(
  parameter int ADR_W            = 18,
  parameter bit SKIP_EMPTY_BEATS = 1'b1
) (
  input  logic                     clk,
  input  logic                     i_rst,
  input  logic                     i_req,
  input  logic                     i_doSave,
  input  logic                     i_doLoad,
  input  logic [BG_ADR_W-1:0]      i_saveAdr,
  input  logic [BG_ADR_W-1:0]      i_loadAdr,
  input  logic [BG_BLOCK_BITS-1:0] i_exportedBGBlock,
  input  logic [15:0]              i_exportedMSKBGBlock,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_importBGBlockSingleClock,
  output logic [BG_BLOCK_BITS-1:0] o_importedBGBlock,
  output logic                     o_memCmdValid,
  input  logic                     i_memCmdReady,
  output logic                     o_memWrite,
  output logic [ADR_W-1:0]         o_memAdr,
  output logic [31:0]              o_memWrData,
  output logic [3:0]               o_memByteEn,
  input  logic                     i_memRdValid,
  input  logic [31:0]              i_memRdData
);

  bgState_e                 r_state;
  bgState_e                 w_nextState;
  logic                     r_doLoad;
  logic                     r_emptyDone;
  logic [BG_ADR_W-1:0]      r_saveAdr;
  logic [BG_ADR_W-1:0]      r_loadAdr;
  logic [BG_BLOCK_BITS-1:0] r_blk;
  logic [15:0]              r_mask;
  logic [BG_BEATS-1:0]      r_pend;      // save beats still to be written
  logic [2:0]               r_beat;      // load command index
  logic [BG_BEATS-1:0]      w_pendInit;
  logic [BG_BEATS-1:0]      w_pendNext;
  logic [2:0]               w_curBeat;
  logic                     w_accept;
  logic                     w_loadStart;
  logic                     w_capture;
  logic                     w_lastBeat;
  logic                     w_isSave;
  logic                     w_isLoad;
  logic [2:0]               w_beat;
  logic [BG_ADR_W-1:0]      w_blkAdr;

  // Empty beats are removed up front, so the save walk jumps straight to the
  // next dirty beat without spending a cycle on the skipped ones.
  always_comb begin
    w_pendInit = '0;
    for (int k = 0; k < BG_BEATS; k++) begin
      w_pendInit[k] = !SKIP_EMPTY_BEATS ||
                      (beat_byte_en(i_exportedMSKBGBlock, 3'(k)) != 4'd0);
    end
  end

  always_comb begin
    w_curBeat = 3'd0;
    for (int k = BG_BEATS - 1; k >= 0; k--) begin
      if (r_pend[k]) w_curBeat = 3'(k);
    end
  end

  assign w_pendNext = r_pend & ~(BG_BEATS'(1) << w_curBeat);

  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_req) begin
          w_accept = 1'b1;
          if (i_doSave && (i_exportedMSKBGBlock != 16'd0)) w_nextState = ST_SAVE;
          else if (i_doLoad)                              w_nextState = ST_LOAD_CMD;
        end
      end
      ST_SAVE: begin
        if (i_memCmdReady && (w_pendNext == '0))
          w_nextState = r_doLoad ? ST_LOAD_CMD : ST_DONE;
      end
      ST_LOAD_CMD: begin
        if (i_memCmdReady && (r_beat == 3'd7))
          w_nextState = w_lastBeat ? ST_DONE : ST_LOAD_WAIT;
      end
      ST_LOAD_WAIT: begin
        if (w_lastBeat) w_nextState = ST_DONE;
      end
      ST_DONE:  w_nextState = ST_IDLE;
      default:  w_nextState = ST_IDLE;
    endcase
  end

  assign w_loadStart = (w_nextState == ST_LOAD_CMD) && (r_state != ST_LOAD_CMD);
  assign w_capture   = i_memRdValid &&
                       ((r_state == ST_LOAD_CMD) || (r_state == ST_LOAD_WAIT));

  gpu_bg_read_assembler u_asm (
    .clk        (clk),
    .i_rst      (i_rst),
    .i_clear    (w_loadStart),
    .i_capture  (w_capture),
    .i_rdData   (i_memRdData),
    .o_block    (o_importedBGBlock),
    .o_lastBeat (w_lastBeat)
  );

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_doLoad    <= 1'b0;
      r_emptyDone <= 1'b0;
      r_saveAdr   <= '0;
      r_loadAdr   <= '0;
      r_blk       <= '0;
      r_mask      <= '0;
      r_pend      <= '0;
      r_beat      <= '0;
    end else begin
      r_state     <= w_nextState;
      // A request with nothing to do completes without ever leaving IDLE.
      r_emptyDone <= w_accept && (w_nextState == ST_IDLE);
      if (w_accept) begin
        r_doLoad  <= i_doLoad;
        r_saveAdr <= i_saveAdr;
        r_loadAdr <= i_loadAdr;
        r_blk     <= i_exportedBGBlock;
        r_mask    <= i_exportedMSKBGBlock;
        r_pend    <= w_pendInit;
      end else if ((r_state == ST_SAVE) && i_memCmdReady) begin
        r_pend    <= w_pendNext;
      end
      if (w_loadStart)
        r_beat <= '0;
      else if ((r_state == ST_LOAD_CMD) && i_memCmdReady)
        r_beat <= r_beat + 3'd1;
    end
  end

  assign w_isSave = (r_state == ST_SAVE);
  assign w_isLoad = (r_state == ST_LOAD_CMD);
  assign w_beat   = w_isSave ? w_curBeat : r_beat;
  assign w_blkAdr = w_isSave ? r_saveAdr : r_loadAdr;

  assign o_busy                     = (r_state != ST_IDLE);
  assign o_done                     = (r_state == ST_DONE) | r_emptyDone;
  assign o_importBGBlockSingleClock = (r_state == ST_DONE) & r_doLoad;
  assign o_memCmdValid              = w_isSave | w_isLoad;
  assign o_memWrite                 = w_isSave;
  assign o_memAdr    = o_memCmdValid ? ADR_W'({w_blkAdr, w_beat}) : '0;
  assign o_memWrData = w_isSave ? r_blk[{w_curBeat, 5'd0} +: 32] : 32'd0;
  assign o_memByteEn = w_isSave ? beat_byte_en(r_mask, w_curBeat) : 4'd0;

`ifndef SYNTHESIS
  // The backend must wait for o_busy to drop; a request now is dropped.
  a_noReqWhileBusy : assert property (@(posedge clk) disable iff (i_rst)
    !(i_req && o_busy))
    else $warning("gpu_bg_block_mover: i_req ignored while busy");
`endif

endmodule
`default_nettype wire
